// File: rtl/bus_ctrl_pkg.sv
// Shared types and constants for the bus writeback sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bus_ctrl_pkg;

    localparam int NUM_REGS_DEF = 16;
    localparam int IDX_W_DEF    = 4;

    // Register index fields inside the instruction register
    localparam int RA_LSB = 23;
    localparam int RA_MSB = 26;
    localparam int RB_LSB = 19;
    localparam int RB_MSB = 22;
    localparam int RC_LSB = 15;
    localparam int RC_MSB = 18;

    localparam logic [1:0] WB_MODE_ZLO     = 2'b00;
    localparam logic [1:0] WB_MODE_PAIR    = 2'b01;
    localparam logic [1:0] WB_MODE_MDR     = 2'b10;
    localparam logic [1:0] WB_MODE_ILLEGAL = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WB_ZLO,
        ST_WB_MDR,
        ST_WB_LO,
        ST_WB_HI,
        ST_DONE
    } wb_state_t;

    // Registered sequencer outputs; ld_ra gates the load enable of R[ra_q]
    typedef struct packed {
        logic ld_ra;
        logic zlo_out;
        logic zhi_out;
        logic mdr_out;
        logic lo_in;
        logic hi_in;
        logic busy;
        logic done;
    } wb_out_t;

    // Moore output decode for a given state
    function automatic wb_out_t state_outputs(input wb_state_t s);
        wb_out_t o;
        o = '0;
        case (s)
            ST_WB_ZLO: begin o.zlo_out = 1'b1; o.ld_ra = 1'b1; end
            ST_WB_MDR: begin o.mdr_out = 1'b1; o.ld_ra = 1'b1; end
            ST_WB_LO:  begin o.zlo_out = 1'b1; o.lo_in = 1'b1; end
            ST_WB_HI:  begin o.zhi_out = 1'b1; o.hi_in = 1'b1; end
            ST_DONE:   o.done = 1'b1;
            default:   o = '0;
        endcase
        o.busy = (s != ST_IDLE);
        return o;
    endfunction

endpackage

// File: rtl/bus_writeback_sequencer_if.sv
// Control-unit side bundle of the writeback sequencer: IR, requests, enables.
// Latency: n/a (wiring only).
// Backpressure: none; busy tells the control unit when requests are masked.
interface bus_writeback_sequencer_if
    import bus_ctrl_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF
) ();

    logic [31:0]         ir;
    logic                Gra;
    logic                Grb;
    logic                Grc;
    logic                Rin;
    logic                Rout;
    logic                BAout;
    logic                wb_start;
    logic [1:0]          wb_mode;

    logic [NUM_REGS-1:0] reg_in;
    logic [NUM_REGS-1:0] reg_out;
    logic                r0_zero;
    logic                zlo_out;
    logic                zhi_out;
    logic                mdr_out;
    logic                lo_in;
    logic                hi_in;
    logic                busy;
    logic                done;
    logic                err;

    modport master (
        output ir, Gra, Grb, Grc, Rin, Rout, BAout, wb_start, wb_mode,
        input  reg_in, reg_out, r0_zero, zlo_out, zhi_out, mdr_out,
               lo_in, hi_in, busy, done, err
    );

    modport slave (
        input  ir, Gra, Grb, Grc, Rin, Rout, BAout, wb_start, wb_mode,
        output reg_in, reg_out, r0_zero, zlo_out, zhi_out, mdr_out,
               lo_in, hi_in, busy, done, err
    );

endinterface

// File: rtl/reg_select_decoder.sv
// Picks one register index field by G priority (a > b > c) and one-hot decodes it.
// Latency: combinational.
// Backpressure: none; no G asserted yields an all-zero vector.
module reg_select_decoder
    import bus_ctrl_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int IDX_W    = IDX_W_DEF
) (
    input  logic [IDX_W-1:0]    ra,
    input  logic [IDX_W-1:0]    rb,
    input  logic [IDX_W-1:0]    rc,
    input  logic                gra,
    input  logic                grb,
    input  logic                grc,
    output logic [NUM_REGS-1:0] onehot
);

    // Priority field select followed by one-hot expansion
    always_comb begin
        onehot = '0;
        if (gra) begin
            onehot[ra] = 1'b1;
        end else if (grb) begin
            onehot[rb] = 1'b1;
        end else if (grc) begin
            onehot[rc] = 1'b1;
        end
    end

endmodule

// File: rtl/bus_writeback_sequencer.sv
// Decodes IR register fields into GPR load/drive enables and sequences Z/MDR writebacks.
// Latency: direct decode combinational; writeback done 2 cycles (single) or 3 (pair) after wb_start.
// Backpressure: while busy, direct requests are masked (err pulse) and wb_start is ignored.
module bus_writeback_sequencer
    import bus_ctrl_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int IDX_W    = IDX_W_DEF
) (
    input  logic                    clk,
    input  logic                    clear,
    bus_writeback_sequencer_if.slave bus
);

    wb_state_t           state_q;
    wb_out_t             out_q;
    logic [IDX_W-1:0]    ra_q;
    logic                err_q;

    logic [NUM_REGS-1:0] dir_oh;
    logic [NUM_REGS-1:0] fsm_oh;
    logic                idle;
    logic                dir_en;
    logic                r0_sel;
    logic                unused_ir_bits;

    // Direct path: field chosen by Gra/Grb/Grc straight from the IR
    reg_select_decoder #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_dir_dec (
        .ra     (bus.ir[RA_LSB +: IDX_W]),
        .rb     (bus.ir[RB_LSB +: IDX_W]),
        .rc     (bus.ir[RC_LSB +: IDX_W]),
        .gra    (bus.Gra),
        .grb    (bus.Grb),
        .grc    (bus.Grc),
        .onehot (dir_oh)
    );

    // Sequencer path: always the Ra index captured at wb_start
    reg_select_decoder #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_fsm_dec (
        .ra     (ra_q),
        .rb     ('0),
        .rc     ('0),
        .gra    (1'b1),
        .grb    (1'b0),
        .grc    (1'b0),
        .onehot (fsm_oh)
    );

    assign unused_ir_bits = ^{bus.ir[31:RA_LSB+IDX_W], bus.ir[RC_LSB-1:0]};

    // Direct requests only act in IDLE and never while reset is asserted
    assign idle   = (state_q == ST_IDLE);
    assign dir_en = clear & idle;

    // BAout on R0 asks the bus mux for a constant zero instead of R0's contents
    assign r0_sel = dir_en & bus.BAout & dir_oh[0];

    assign bus.reg_in  = ((dir_en & bus.Rin) ? dir_oh : '0)
                       | (out_q.ld_ra ? fsm_oh : '0);
    assign bus.reg_out = (dir_en & (bus.Rout | bus.BAout) & ~r0_sel) ? dir_oh : '0;
    assign bus.r0_zero = r0_sel;
    assign bus.zlo_out = out_q.zlo_out;
    assign bus.zhi_out = out_q.zhi_out;
    assign bus.mdr_out = out_q.mdr_out;
    assign bus.lo_in   = out_q.lo_in;
    assign bus.hi_in   = out_q.hi_in;
    assign bus.busy    = out_q.busy;
    assign bus.done    = out_q.done;
    assign bus.err     = err_q;

    // Writeback FSM: state, captured index, error pulse and registered Moore outputs
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q <= ST_IDLE;
            out_q   <= '0;
            ra_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= ~idle & (bus.Rin | bus.Rout | bus.BAout);
            case (state_q)
                ST_IDLE: begin
                    if (bus.wb_start) begin
                        ra_q <= bus.ir[RA_LSB +: IDX_W];
                        case (bus.wb_mode)
                            WB_MODE_ZLO: begin
                                state_q <= ST_WB_ZLO;
                                out_q   <= state_outputs(ST_WB_ZLO);
                            end
                            WB_MODE_PAIR: begin
                                state_q <= ST_WB_LO;
                                out_q   <= state_outputs(ST_WB_LO);
                            end
                            WB_MODE_MDR: begin
                                state_q <= ST_WB_MDR;
                                out_q   <= state_outputs(ST_WB_MDR);
                            end
                            default: begin
                                err_q   <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_WB_LO: begin
                    state_q <= ST_WB_HI;
                    out_q   <= state_outputs(ST_WB_HI);
                end
                ST_WB_ZLO, ST_WB_MDR, ST_WB_HI: begin
                    state_q <= ST_DONE;
                    out_q   <= state_outputs(ST_DONE);
                end
                default: begin
                    state_q <= ST_IDLE;
                    out_q   <= state_outputs(ST_IDLE);
                end
            endcase
        end
    end

endmodule

// File: doc/bus_writeback_sequencer.md
Name: bus_writeback_sequencer

Overview:
- Receive-side counterpart of the datapath bus-driver encoder/mux: decodes IR register fields into one-hot register load (Rin) and drive (Rout) enables.
- Sequences multi-cycle bus writebacks: Z-low to a GPR, MDR to a GPR, and the 64-bit Z pair to LO then HI.
- Sits between the control unit and the register/bus-select logic; guarantees at most one bus driver and a well-defined load target per cycle.

Parameters:
- NUM_REGS, 16, number of general-purpose registers (one-hot width of reg_in/reg_out).
- IDX_W, 4, width of a register index field in the IR.

Ports:
- clk  in  1  system clock, rising edge.
- clear  in  1  reset, asynchronous, active-low.
- ir  in  32  instruction register; Ra=ir[26:23], Rb=ir[22:19], Rc=ir[18:15].
- Gra, Grb, Grc  in  1 each  field select for direct decode.
- Rin, Rout, BAout  in  1 each  direct load/drive request for the selected field.
- wb_start  in  1  start writeback sequence (sampled in IDLE only).
- wb_mode  in  2  00 Zlo->R[Ra]; 01 Zlo->LO then Zhi->HI; 10 MDR->R[Ra]; 11 illegal.
- reg_in  out  NUM_REGS  one-hot GPR load enables.
- reg_out  out  NUM_REGS  one-hot GPR bus-drive enables.
- r0_zero  out  1  BAout with R0 selected; bus mux must drive 0.
- zlo_out, zhi_out, mdr_out  out  1 each  special-register bus-drive enables.
- lo_in, hi_in  out  1 each  LO/HI load enables.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle error pulse.

Behaviour:
- Reset (clear=0, async): state=IDLE, captured index=0, err register=0. All outputs are 0 immediately, including mid-sequence.
- Direct decode (combinational, effective only in IDLE):
  - Field priority is Gra > Grb > Grc; no G asserted means no enable.
  - Rin sets reg_in[idx]; Rout or BAout sets reg_out[idx].
  - BAout with idx=0 sets r0_zero=1 and leaves reg_out[0]=0.
- FSM (Moore, registered state; outputs decoded from state only). States: IDLE, WB_ZLO, WB_MDR, WB_LO, WB_HI, DONE.
  - IDLE + wb_start: capture Ra into ra_q, then mode 00->WB_ZLO, 01->WB_LO, 10->WB_MDR, 11->stay IDLE with err=1 next cycle.
  - WB_ZLO: zlo_out=1, reg_in[ra_q]=1 -> DONE.
  - WB_MDR: mdr_out=1, reg_in[ra_q]=1 -> DONE.
  - WB_LO: zlo_out=1, lo_in=1 -> WB_HI.
  - WB_HI: zhi_out=1, hi_in=1 -> DONE.
  - DONE: done=1 -> IDLE.
- busy=1 in every state except IDLE.
- Latency from wb_start to done: 2 cycles single, 3 cycles pair.
- Fixed ra_q: ra_q is captured at start; ir changes mid-sequence have no effect.
- Collisions while busy:
  - Rin/Rout/BAout are masked (no enables) and err pulses the next cycle.
  - wb_start is ignored with no error.
- Simultaneous wb_start and a direct request in IDLE: both honoured that cycle, since direct decode is combinational and the FSM acts next cycle.
- Invariant: among reg_out, r0_zero, zlo_out, zhi_out and mdr_out, at most one bit is set per cycle, given legal direct inputs.

Decomposition:
- Package bus_ctrl_pkg:
  - state enum;
  - WB_MODE_* constants;
  - IR field LSB/MSB constants (RA_LSB=23, RB_LSB=19, RC_LSB=15);
  - NUM_REGS default.
- Sub-module reg_select_decoder: G-priority field mux plus 4-to-16 one-hot decode. Instantiated twice, once for the direct path and once on ra_q for the FSM path.

Test Plan:
- Reset mid-sequence: assert clear=0 while in WB_LO -> all outputs 0 at once; state IDLE after release; done never pulses.
- Direct decode: ir Ra=5, Rb=9; Grb=1, Rin=1 -> reg_in=16'h0200, reg_out=0. Gra=1, Grb=1, Rout=1 -> reg_out=16'h0020.
- BAout on R0: ir Rb=0; Grb=1, BAout=1 -> r0_zero=1, reg_out=0.
- Pair writeback: wb_mode=01, wb_start for 1 cycle -> cycle+1 zlo_out & lo_in; cycle+2 zhi_out & hi_in; cycle+3 done=1; busy high for cycles+1..+3.
- Single writeback with IR change: wb_mode=00, Ra=3, then Ra changed to 7 next cycle -> reg_in=16'h0008 with zlo_out=1, then done.
- Illegal mode and collision: wb_mode=11 -> err=1 for one cycle, busy=0. During WB_MDR, Grc=1, Rin=1 -> reg_in only R[ra_q], err=1 the next cycle.
